// File: rtl/mult_arb_sched.sv
// ----------------------------------------------------------------------------
// mult_arb_sched
//
// Purpose:
//    Round-robin arbiter and sequencer that lets four requesters share one
//    4x4 shift-add multiplier. A job runs IDLE -> ISSUE -> WAIT -> DELIVER.
//    The winner's operands are latched when it is picked and stay fixed on
//    o_m_a/o_m_b until the job ends. Every output is registered.
//
// Optional feature:
//    MULT_ARB_TIMEOUT_EN - when defined, a WAIT that runs TIMEOUT_CYC cycles
//    without an accepted i_m_ready is aborted. The requester then gets DONE
//    with RESULT=0 and TIMEOUT=1. When undefined, WAIT has no limit and
//    o_timeout is tied to 0.
//
// Ports:
//    i_ck        rising-edge clock
//    i_rst       synchronous active-high reset
//    i_req[3:0]  per-requester request, held until the matching grant
//    i_a_in[15:0], i_b_in[15:0]
//                packed 4-bit operands, requester i uses bits [4i+3:4i]
//    o_gnt[3:0]  one-hot, one-cycle acceptance pulse (ISSUE)
//    o_done[3:0] one-hot, one-cycle completion pulse (DELIVER)
//    o_result[7:0]
//                product, nonzero only during DELIVER
//    o_timeout   pulses with o_done when the job was aborted
//    o_busy      high in every state except IDLE
//    o_m_start   multiplier start strobe
//    o_m_a, o_m_b
//                multiplier operands
//    i_m_ready   multiplier ready, stays high until the next start
//    i_m_p[7:0]  multiplier product
// ----------------------------------------------------------------------------
module mult_arb_sched #(
   parameter int TIMEOUT_CYC = 12
) (
   input  logic        i_ck,
   input  logic        i_rst,
   input  logic [3:0]  i_req,
   input  logic [15:0] i_a_in,
   input  logic [15:0] i_b_in,
   output logic [3:0]  o_gnt,
   output logic [3:0]  o_done,
   output logic [7:0]  o_result,
   output logic        o_timeout,
   output logic        o_busy,
   output logic        o_m_start,
   output logic [3:0]  o_m_a,
   output logic [3:0]  o_m_b,
   input  logic        i_m_ready,
   input  logic [7:0]  i_m_p
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

   state_t      r_state;
   logic [1:0]  r_w;
   logic [1:0]  r_last_w;
   logic        r_wait_first;
   logic [3:0]  r_gnt;
   logic [3:0]  r_done;
   logic [7:0]  r_result;
   logic        r_busy;
   logic        r_m_start;
   logic [3:0]  r_m_a;
   logic [3:0]  r_m_b;

   logic        w_found;
   logic [1:0]  w_win;
   logic [1:0]  w_idx;
   logic [3:0]  w_sel_a;
   logic [3:0]  w_sel_b;
   logic [3:0]  w_w_onehot;

   // Round-robin search. It starts at the requester after the last winner,
   // so the last winner has the lowest priority.
   always_comb begin
      w_found = 1'b0;
      w_win   = 2'd0;
      w_idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_last_w + 2'(k + 1);
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_sel_a    = i_a_in[{w_win, 2'b00} +: 4];
   assign w_sel_b    = i_b_in[{w_win, 2'b00} +: 4];
   assign w_w_onehot = 4'b0001 << r_w;

`ifdef MULT_ARB_TIMEOUT_EN
   logic [3:0] r_cnt;
   logic       r_timeout;
   logic       w_cnt_hit;

   // The count ends at TIMEOUT_CYC on the WAIT cycle that would take the
   // count to TIMEOUT_CYC.
   assign w_cnt_hit = ((r_cnt + 4'd1) == 4'(TIMEOUT_CYC));
   assign o_timeout = r_timeout;
`else
   // The parameter matters only when the timeout feature is built in.
   // Here this expression is always 0.
   assign o_timeout = 1'b0 & (TIMEOUT_CYC != 0);
`endif

   always_ff @(posedge i_ck) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_w          <= 2'd0;
         r_last_w     <= 2'd3;
         r_wait_first <= 1'b0;
         r_gnt        <= 4'd0;
         r_done       <= 4'd0;
         r_result     <= 8'd0;
         r_busy       <= 1'b0;
         r_m_start    <= 1'b0;
         r_m_a        <= 4'd0;
         r_m_b        <= 4'd0;
`ifdef MULT_ARB_TIMEOUT_EN
         r_cnt        <= 4'd0;
         r_timeout    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_w       <= w_win;
                  r_gnt     <= 4'b0001 << w_win;
                  r_m_start <= 1'b1;
                  r_m_a     <= w_sel_a;
                  r_m_b     <= w_sel_b;
                  r_busy    <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_gnt        <= 4'd0;
               r_m_start    <= 1'b0;
               r_last_w     <= r_w;
               r_wait_first <= 1'b1;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               // In the first WAIT cycle, ready may still be high from the
               // previous job, so it is not used.
               r_wait_first <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
               r_cnt        <= r_cnt + 4'd1;
`endif
               if (!r_wait_first && i_m_ready) begin
                  r_result <= i_m_p;
                  r_done   <= w_w_onehot;
                  r_state  <= S_DELIVER;
`ifdef MULT_ARB_TIMEOUT_EN
                  r_cnt    <= 4'd0;
               end else if (w_cnt_hit) begin
                  r_result  <= 8'd0;
                  r_done    <= w_w_onehot;
                  r_timeout <= 1'b1;
                  r_cnt     <= 4'd0;
                  r_state   <= S_DELIVER;
`endif
               end
            end
            S_DELIVER: begin
               r_done   <= 4'd0;
               r_result <= 8'd0;
               r_busy   <= 1'b0;
               r_m_a    <= 4'd0;
               r_m_b    <= 4'd0;
`ifdef MULT_ARB_TIMEOUT_EN
               r_timeout <= 1'b0;
`endif
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_gnt     = r_gnt;
   assign o_done    = r_done;
   assign o_result  = r_result;
   assign o_busy    = r_busy;
   assign o_m_start = r_m_start;
   assign o_m_a     = r_m_a;
   assign o_m_b     = r_m_b;

endmodule

// File: tb/tb_mult_arb_sched.sv
// ----------------------------------------------------------------------------
// tb_mult_arb_sched
//
// Testbench for mult_arb_sched. Directed jobs push the grants and completions
// they expect into two queues. A monitor on the falling edge pops an entry
// and compares it each time the DUT shows a GNT or a DONE pulse. A behavioral
// model of the multiplier has a settable latency. It can also keep a stale
// ready for one cycle after start, or hold ready low.
// ----------------------------------------------------------------------------
module tb_mult_arb_sched;

   logic        ck = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'd0;
   logic [15:0] a_in = 16'd0;
   logic [15:0] b_in = 16'd0;
   logic        m_ready = 1'b1;
   logic [7:0]  m_p = 8'd0;
   logic [3:0]  o_gnt, o_done, o_m_a, o_m_b;
   logic [7:0]  o_result;
   logic        o_timeout, o_busy, o_m_start;

   always #5 ck = ~ck;

   mult_arb_sched #(.TIMEOUT_CYC(12)) dut (
      .i_ck      (ck),
      .i_rst     (rst),
      .i_req     (req),
      .i_a_in    (a_in),
      .i_b_in    (b_in),
      .o_gnt     (o_gnt),
      .o_done    (o_done),
      .o_result  (o_result),
      .o_timeout (o_timeout),
      .o_busy    (o_busy),
      .o_m_start (o_m_start),
      .o_m_a     (o_m_a),
      .o_m_b     (o_m_b),
      .i_m_ready (m_ready),
      .i_m_p     (m_p)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge ck) cyc <= cyc + 1;

   // gap: cycles since the previous grant. lat: cycles from grant to done.
   // A value of 0 means that check is skipped.
   typedef struct { logic [3:0] gnt; logic [3:0] a; logic [3:0] b; int gap; } gexp_t;
   typedef struct { logic [3:0] done; logic [7:0] res; logic to; int lat; } dexp_t;
   gexp_t gq[$];
   dexp_t dq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Multiplier model. Start is sampled on a rising edge. Ready comes back
   // mult_lat edges later with the product. With stale set, the old ready
   // and product stay for one cycle after start.
   int         mult_lat = 5;
   bit         stale = 1'b0;
   bit         hold0 = 1'b0;
   int         mcnt = 0;
   logic [7:0] pend = 8'd0;

   always @(posedge ck) begin
      if (rst) begin
         m_ready <= 1'b1;
         m_p     <= 8'd0;
         mcnt    <= 0;
      end else if (hold0) begin
         m_ready <= 1'b0;
      end else if (o_m_start) begin
         pend <= {4'd0, o_m_a} * {4'd0, o_m_b};
         mcnt <= 1;
         if (!stale) m_ready <= 1'b0;
      end else if (mcnt != 0) begin
         if (mcnt == mult_lat) begin
            m_ready <= 1'b1;
            m_p     <= pend;
            mcnt    <= 0;
         end else begin
            if (mcnt == 1) m_ready <= 1'b0;
            mcnt <= mcnt + 1;
         end
      end
   end

   // Monitor
   int    last_gnt_cyc = 0;
   gexp_t g;
   dexp_t d;

   always @(negedge ck) begin
      if (!rst) begin
         chk("gnt_done_excl", 32'((o_gnt != 0) && (o_done != 0)), 32'd0);
         chk("start_with_gnt", 32'(o_m_start), 32'(|o_gnt));
         if (o_done == 4'd0) begin
            chk("result_outside_deliver", 32'(o_result), 32'd0);
            chk("timeout_outside_deliver", 32'(o_timeout), 32'd0);
         end
         if (o_gnt != 4'd0) begin
            if (gq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_gnt: got %b expected none", o_gnt);
            end else begin
               g = gq.pop_front();
               chk("gnt", 32'(o_gnt), 32'(g.gnt));
               chk("m_a", 32'(o_m_a), 32'(g.a));
               chk("m_b", 32'(o_m_b), 32'(g.b));
               if (g.gap != 0) chk("gnt_gap", 32'(cyc - last_gnt_cyc), 32'(g.gap));
               $display("gnt  %b m_a=%0d m_b=%0d cycle=%0d", o_gnt, o_m_a, o_m_b, cyc);
            end
            last_gnt_cyc = cyc;
         end
         if (o_done != 4'd0) begin
            if (dq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got %b expected none", o_done);
            end else begin
               d = dq.pop_front();
               chk("done", 32'(o_done), 32'(d.done));
               chk("result", 32'(o_result), 32'(d.res));
               chk("timeout", 32'(o_timeout), 32'(d.to));
               chk("busy_in_deliver", 32'(o_busy), 32'd1);
               if (d.lat != 0) chk("latency", 32'(cyc - last_gnt_cyc), 32'(d.lat));
               $display("done %b result=%0d timeout=%0d cycle=%0d", o_done, o_result, o_timeout, cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic wait_gnt(input logic [3:0] m);
      for (int i = 0; i < 100; i++) begin
         tick();
         if ((o_gnt & m) != 4'd0) return;
      end
      n_cmp++; n_bad++;
      $display("FAIL wait_gnt: got no grant expected mask %b", m);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!o_busy) return;
      end
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: got busy expected idle");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},     32'(o_gnt),     32'd0);
      chk({tag, "_done"},    32'(o_done),    32'd0);
      chk({tag, "_result"},  32'(o_result),  32'd0);
      chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
      chk({tag, "_busy"},    32'(o_busy),    32'd0);
      chk({tag, "_m_start"}, 32'(o_m_start), 32'd0);
      chk({tag, "_m_a"},     32'(o_m_a),     32'd0);
      chk({tag, "_m_b"},     32'(o_m_b),     32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, then a single job: 7*9 with a 5-cycle multiplier.
      rst = 1'b1;
      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b0;
      mult_lat = 5;
      a_in = 16'h0007;
      b_in = 16'h0009;
      gq.push_back('{4'b0001, 4'd7, 4'd9, 0});
      dq.push_back('{4'b0001, 8'd63, 1'b0, 7});
      req = 4'b0001;
      wait_gnt(4'b0001);
      req = 4'b0000;
      wait_idle();

      // All four requesting, with minimum latency and back-to-back jobs.
      do_reset();
      mult_lat = 1;
      a_in = 16'h4321;
      b_in = 16'hFFFF;
      gq.push_back('{4'b0001, 4'd1, 4'd15, 0});
      gq.push_back('{4'b0010, 4'd2, 4'd15, 5});
      gq.push_back('{4'b0100, 4'd3, 4'd15, 5});
      gq.push_back('{4'b1000, 4'd4, 4'd15, 5});
      gq.push_back('{4'b0001, 4'd1, 4'd15, 5});
      dq.push_back('{4'b0001, 8'd15, 1'b0, 3});
      dq.push_back('{4'b0010, 8'd30, 1'b0, 3});
      dq.push_back('{4'b0100, 8'd45, 1'b0, 3});
      dq.push_back('{4'b1000, 8'd60, 1'b0, 3});
      dq.push_back('{4'b0001, 8'd15, 1'b0, 3});
      req = 4'b1111;
      for (int k = 0; k < 5; k++) wait_gnt(4'b1111);
      req = 4'b0000;
      wait_idle();

      // Ready is still high from the last job (product 15). The new job,
      // 6*7, must return 42.
      stale = 1'b1;
      mult_lat = 4;
      a_in = 16'h0600;
      b_in = 16'h0700;
      gq.push_back('{4'b0100, 4'd6, 4'd7, 0});
      dq.push_back('{4'b0100, 8'd42, 1'b0, 6});
      req = 4'b0100;
      wait_gnt(4'b0100);
      req = 4'b0000;
      wait_idle();
      stale = 1'b0;

      // Reset in the second WAIT cycle. The job must give no DONE, and
      // requester 0 must win before requester 3.
      mult_lat = 5;
      a_in = 16'h0003;
      b_in = 16'h0003;
      gq.push_back('{4'b0001, 4'd3, 4'd3, 0});
      req = 4'b0001;
      wait_gnt(4'b0001);
      req = 4'b0000;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_all_zero("midjob_reset");
      rst = 1'b0;
      a_in = 16'h2004;
      b_in = 16'h5004;
      gq.push_back('{4'b0001, 4'd4, 4'd4, 0});
      gq.push_back('{4'b1000, 4'd2, 4'd5, 9});
      dq.push_back('{4'b0001, 8'd16, 1'b0, 7});
      dq.push_back('{4'b1000, 8'd10, 1'b0, 7});
      req = 4'b1001;
      wait_gnt(4'b0001);
      req = 4'b1000;
      wait_gnt(4'b1000);
      req = 4'b0000;
      wait_idle();

      // Multiplier never becomes ready.
      hold0 = 1'b1;
      a_in = 16'h0050;
      b_in = 16'h0050;
      gq.push_back('{4'b0010, 4'd5, 4'd5, 0});
`ifdef MULT_ARB_TIMEOUT_EN
      dq.push_back('{4'b0010, 8'd0, 1'b1, 13});
      req = 4'b0010;
      wait_gnt(4'b0010);
      req = 4'b0000;
      wait_idle();
      // Ready arrives in the same cycle the count expires, so ready wins.
      hold0 = 1'b0;
      mult_lat = 11;
      gq.push_back('{4'b0010, 4'd5, 4'd5, 0});
      dq.push_back('{4'b0010, 8'd25, 1'b0, 13});
      req = 4'b0010;
      wait_gnt(4'b0010);
      req = 4'b0000;
      wait_idle();
`else
      req = 4'b0010;
      wait_gnt(4'b0010);
      req = 4'b0000;
      for (int k = 0; k < 100; k++) begin
         tick();
         chk("busy_hold", 32'(o_busy), 32'd1);
         chk("timeout_zero", 32'(o_timeout), 32'd0);
      end
      hold0 = 1'b0;
      do_reset();
`endif

      tick();
      tick();
      chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
      chk("done_queue_empty", 32'(dq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
